sdram_arbiter: RTL and testbench

Two-port arbiter that shares the single SDRAM controller between the CPU memory bus and a DMA/video master. Each port speaks the native valid/ready memory handshake. The arbiter launches at most one 32-bit access per controller cycle slot, aligned to the controller's cycle start. It sits between the picosoc bus fabric and `sdram`, driving its `addr/we/oeA/dqm/din` inputs and consuming `dout/ready`.

---
 rtl/sdram_arbiter_pkg.sv | 13 +
 rtl/sdram_arbiter_rr_arb2.sv | 12 +
 rtl/sdram_arbiter.sv | 139 +++++++++++++
 tb/tb_sdram_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arbiter_pkg.sv
// Shared types for the two-port SDRAM arbiter: FSM state encoding and port indices.
package sdram_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy  = 2'd1,
    StDrain = 2'd2
  } state_e;

  localparam logic PortCpu = 1'b0;
  localparam logic PortDma = 1'b1;

endpackage

// File: rtl/sdram_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the port that did not win last time is chosen.
module sdram_arbiter_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       grant,
  output logic       any
);

  assign any   = |valid;
  assign grant = (&valid) ? ~last : valid[1];

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller between CPU (p0) and DMA (p1), launching at most one access
// per controller cycle, registered on the cycle_start strobe.
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 26
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cycle_start,
  input  logic              p0_valid,
  input  logic              p1_valid,
  input  logic [31:0]       p0_addr,
  input  logic [31:0]       p1_addr,
  input  logic [31:0]       p0_wdata,
  input  logic [31:0]       p1_wdata,
  input  logic [3:0]        p0_wstrb,
  input  logic [3:0]        p1_wstrb,
  output logic              p0_ready,
  output logic              p1_ready,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic              ctrl_we,
  output logic              ctrl_oe,
  output logic [3:0]        ctrl_dqm,
  output logic [31:0]       ctrl_din,
  input  logic [31:0]       ctrl_dout,
  input  logic              ctrl_ready
);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d, oe_q, oe_d;
  logic [3:0]        dqm_q, dqm_d;
  logic [31:0]       din_q, din_d, rdata_q, rdata_d;
  logic              rdy0_q, rdy0_d, rdy1_q, rdy1_d;

  logic        pick, any_valid;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        unused_addr;

  sdram_arbiter_rr_arb2 u_rr (
    .valid ({p1_valid, p0_valid}),
    .last  (last_q),
    .grant (pick),
    .any   (any_valid)
  );

  assign sel_addr  = (pick == PortDma) ? p1_addr  : p0_addr;
  assign sel_wdata = (pick == PortDma) ? p1_wdata : p0_wdata;
  assign sel_wstrb = (pick == PortDma) ? p1_wstrb : p0_wstrb;

  // Upper address bits beyond the controller's reach and the byte offset are dropped.
  assign unused_addr = ^{p0_addr[31:ADDR_W], p0_addr[1:0], p1_addr[31:ADDR_W], p1_addr[1:0]};

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    oe_d    = oe_q;
    dqm_d   = dqm_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    rdy0_d  = 1'b0;
    rdy1_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cycle_start && any_valid) begin
          gnt_d   = pick;
          last_d  = pick;
          addr_d  = {sel_addr[ADDR_W-1:2], 2'b00};
          we_d    = |sel_wstrb;
          oe_d    = ~|sel_wstrb;
          dqm_d   = ~sel_wstrb;
          din_d   = sel_wdata;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (ctrl_ready) begin
          if (oe_q) rdata_d = ctrl_dout;
          // A master that abandoned its request gets no completion pulse.
          if (gnt_q == PortCpu) rdy0_d = p0_valid;
          else                  rdy1_d = p1_valid;
          we_d    = 1'b0;
          oe_d    = 1'b0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!ctrl_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      gnt_q   <= PortCpu;
      addr_q  <= '0;
      we_q    <= 1'b0;
      oe_q    <= 1'b0;
      dqm_q   <= 4'h0;
      din_q   <= 32'h0;
      rdata_q <= 32'h0;
      rdy0_q  <= 1'b0;
      rdy1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      oe_q    <= oe_d;
      dqm_q   <= dqm_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      rdy0_q  <= rdy0_d;
      rdy1_q  <= rdy1_d;
    end
  end

  assign p0_ready  = rdy0_q;
  assign p1_ready  = rdy1_q;
  assign rdata     = rdata_q;
  assign ctrl_addr = addr_q;
  assign ctrl_we   = we_q;
  assign ctrl_oe   = oe_q;
  assign ctrl_dqm  = dqm_q;
  assign ctrl_din  = din_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a transaction-level model checked every cycle, plus
// hand-computed expectations for the listed scenarios.
module tb_sdram_arbiter;
  localparam int unsigned ADDR_W = 26;

  logic clk = 1'b0, resetn = 1'b1, cycle_start = 1'b0;
  logic p0_valid = 1'b0, p1_valid = 1'b0;
  logic [31:0] p0_addr = '0, p1_addr = '0, p0_wdata = '0, p1_wdata = '0;
  logic [3:0] p0_wstrb = '0, p1_wstrb = '0;
  logic p0_ready, p1_ready;
  logic [31:0] rdata;
  logic [ADDR_W-1:0] ctrl_addr;
  logic ctrl_we, ctrl_oe;
  logic [3:0] ctrl_dqm;
  logic [31:0] ctrl_din;
  logic [31:0] ctrl_dout = '0;
  logic ctrl_ready = 1'b0;

  sdram_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn), .cycle_start(cycle_start),
    .p0_valid(p0_valid), .p1_valid(p1_valid), .p0_addr(p0_addr), .p1_addr(p1_addr),
    .p0_wdata(p0_wdata), .p1_wdata(p1_wdata), .p0_wstrb(p0_wstrb), .p1_wstrb(p1_wstrb),
    .p0_ready(p0_ready), .p1_ready(p1_ready), .rdata(rdata),
    .ctrl_addr(ctrl_addr), .ctrl_we(ctrl_we), .ctrl_oe(ctrl_oe), .ctrl_dqm(ctrl_dqm),
    .ctrl_din(ctrl_din), .ctrl_dout(ctrl_dout), .ctrl_ready(ctrl_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction model: an access is outstanding from launch until the controller says done,
  // after which nothing may launch until ctrl_ready falls.
  logic m_outstanding = 1'b0, m_waitlow = 1'b0, m_last = 1'b1, m_owner = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic m_we = 1'b0, m_oe = 1'b0, m_r0 = 1'b0, m_r1 = 1'b0;
  logic [3:0] m_dqm = '0;
  logic [31:0] m_din = '0, m_rdata = '0;
  logic m_pick;
  logic [31:0] m_a, m_d;
  logic [3:0] m_s;

  // Both requesting: the one that was not served last; otherwise whoever asks.
  assign m_pick = (p0_valid && p1_valid) ? (m_last == 1'b1 ? 1'b0 : 1'b1)
                                         : (p0_valid ? 1'b0 : 1'b1);
  assign m_a = m_pick ? p1_addr : p0_addr;
  assign m_d = m_pick ? p1_wdata : p0_wdata;
  assign m_s = m_pick ? p1_wstrb : p0_wstrb;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_outstanding <= 0; m_waitlow <= 0; m_last <= 1; m_owner <= 0;
      m_addr <= '0; m_we <= 0; m_oe <= 0; m_dqm <= '0; m_din <= '0; m_rdata <= '0;
      m_r0 <= 0; m_r1 <= 0;
    end else begin
      m_r0 <= 0;
      m_r1 <= 0;
      if (m_outstanding && ctrl_ready) begin
        m_outstanding <= 0;
        m_waitlow <= 1;
        if (m_oe) m_rdata <= ctrl_dout;
        m_r0 <= (m_owner == 0) && p0_valid;
        m_r1 <= (m_owner == 1) && p1_valid;
        m_we <= 0;
        m_oe <= 0;
      end else if (m_waitlow) begin
        if (!ctrl_ready) m_waitlow <= 0;
      end else if (!m_outstanding && cycle_start && (p0_valid || p1_valid)) begin
        m_outstanding <= 1;
        m_owner <= m_pick;
        m_last <= m_pick;
        m_addr <= ADDR_W'(m_a & 32'hFFFF_FFFC);
        m_we <= (m_s != 0);
        m_oe <= (m_s == 0);
        m_dqm <= 4'hF ^ m_s;
        m_din <= m_d;
      end
    end
  end

  int errors = 0, checks = 0;
  int p0_cnt = 0, p1_cnt = 0, p0_cyc = -1;
  logic [ADDR_W-1:0] s1_addr;
  logic s1_we, s1_oe, s10_weoe;
  logic [3:0] s1_dqm;
  logic [31:0] s1_din, s9_rdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_all();
    check("p0_ready", 64'(p0_ready), 64'(m_r0));
    check("p1_ready", 64'(p1_ready), 64'(m_r1));
    check("rdata", 64'(rdata), 64'(m_rdata));
    check("ctrl_addr", 64'(ctrl_addr), 64'(m_addr));
    check("ctrl_we", 64'(ctrl_we), 64'(m_we));
    check("ctrl_oe", 64'(ctrl_oe), 64'(m_oe));
    check("ctrl_dqm", 64'(ctrl_dqm), 64'(m_dqm));
    check("ctrl_din", 64'(ctrl_din), 64'(m_din));
    if (p0_ready) begin p0_cnt++; p0_cyc = cyc; end
    if (p1_ready) p1_cnt++;
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  // One 16-clock controller slot. mode: 0 normal, 1 p0 valid appears in C3,
  // 2 reset pulse in C4, 3 extra cycle_start in C9 (DRAIN), 4 both valids dropped in C3.
  int c0;
  task automatic slot(input logic [31:0] dout, input int mode);
    c0 = cyc;
    for (int c = 0; c < 16; c++) begin
      cycle_start = (c == 0) || (mode == 3 && c == 9);
      ctrl_ready = (c == 8 || c == 9);
      ctrl_dout = dout;
      if (mode == 1 && c == 3) p0_valid = 1;
      if (mode == 4 && c == 3) begin p0_valid = 0; p1_valid = 0; end
      if (mode == 2 && c == 5) resetn = 1;
      if (mode == 2 && c == 4) begin
        resetn = 0;
        #1;
        check("rst_mid_ctrl", {ctrl_addr, ctrl_we, ctrl_oe, ctrl_dqm}, 64'h0);
        check("rst_mid_data", {rdata, ctrl_din}, 64'h0);
        check("rst_mid_ready", {p0_ready, p1_ready}, 64'h0);
      end
      if (c == 1) begin
        s1_addr = ctrl_addr; s1_we = ctrl_we; s1_oe = ctrl_oe; s1_dqm = ctrl_dqm; s1_din = ctrl_din;
      end
      if (c == 9) s9_rdata = rdata;
      if (c == 10) s10_weoe = ctrl_we | ctrl_oe;
      tick();
    end
    cycle_start = 0;
    ctrl_ready = 0;
  endtask

  int b0, b1;
  initial begin
    #1 resetn = 0;
    repeat (3) tick();
    check("reset_outputs", {ctrl_addr, ctrl_we, ctrl_oe, ctrl_dqm, p0_ready, p1_ready}, 64'h0);
    check("reset_data", {rdata, ctrl_din}, 64'h0);
    resetn = 1;
    repeat (2) tick();

    // p0 read
    p0_addr = 32'h0000_1000; p0_wstrb = 4'h0; p0_valid = 1;
    b0 = p0_cnt; b1 = p1_cnt; p0_cyc = -1;
    slot(32'hDEAD_BEEF, 0);
    p0_valid = 0;
    check("rd_c1_oe", 64'(s1_oe), 64'h1);
    check("rd_c1_addr", 64'(s1_addr), 64'h0001000);
    check("rd_ready_c9", 64'(p0_cyc - c0), 64'd9);
    check("rd_rdata", 64'(s9_rdata), 64'hDEADBEEF);
    check("rd_p0_pulses", 64'(p0_cnt - b0), 64'd1);
    check("rd_p1_pulses", 64'(p1_cnt - b1), 64'd0);

    // p1 write
    p1_addr = 32'h0123_4566; p1_wstrb = 4'b0011; p1_wdata = 32'hA5A5_5A5A; p1_valid = 1;
    b1 = p1_cnt;
    slot(32'h0, 0);
    p1_valid = 0;
    check("wr_we", 64'(s1_we), 64'h1);
    check("wr_dqm", 64'(s1_dqm), 64'hC);
    check("wr_addr", 64'(s1_addr), 64'h1234564);
    check("wr_din", 64'(s1_din), 64'hA5A55A5A);
    check("wr_p1_pulses", 64'(p1_cnt - b1), 64'd1);

    // both valid for 4 slots: p0, p1, p0, p1
    p0_addr = 32'h0000_2000; p0_wstrb = 0;
    p1_addr = 32'h0000_3004; p1_wstrb = 4'hF; p1_wdata = 32'h1111_2222;
    p0_valid = 1; p1_valid = 1;
    for (int s = 0; s < 4; s++) begin
      b0 = p0_cnt; b1 = p1_cnt;
      slot(32'h5000_0000 + 32'(s), 0);
      check("rr_p0_pulse", 64'(p0_cnt - b0), (s % 2 == 0) ? 64'd1 : 64'd0);
      check("rr_p1_pulse", 64'(p1_cnt - b1), (s % 2 == 0) ? 64'd0 : 64'd1);
    end
    p0_valid = 0; p1_valid = 0;

    // valid arrives after the strobe: waits a full slot
    p0_addr = 32'h0000_4008; p0_wstrb = 0;
    b0 = p0_cnt;
    slot(32'h7777_0001, 1);
    check("late_no_launch", {s10_weoe, s1_we, s1_oe}, 64'h0);
    check("late_no_pulse", 64'(p0_cnt - b0), 64'd0);
    slot(32'h7777_0002, 0);
    check("late_then_pulse", 64'(p0_cnt - b0), 64'd1);
    check("late_rdata", 64'(s9_rdata), 64'h77770002);
    p0_valid = 0;

    // reset in C4 of a p0 read
    p0_addr = 32'h0000_5000; p0_valid = 1;
    b0 = p0_cnt;
    slot(32'h0BAD_0BAD, 2);
    p0_valid = 0;
    check("rst_no_pulse", 64'(p0_cnt - b0), 64'd0);
    check("rst_rdata_clear", 64'(s9_rdata), 64'h0);

    // cycle_start during DRAIN launches nothing
    p1_addr = 32'h0000_6000; p1_wstrb = 4'h1; p1_wdata = 32'hCAFE_F00D; p1_valid = 1;
    b1 = p1_cnt;
    slot(32'h0, 3);
    p1_valid = 0;
    check("drain_one_pulse", 64'(p1_cnt - b1), 64'd1);
    check("drain_no_launch", 64'(s10_weoe), 64'h0);

    // master drops valid mid-access: no pulse, rdata still updated
    p0_addr = 32'h0000_7000; p0_wstrb = 0; p0_valid = 1;
    b0 = p0_cnt;
    slot(32'h1234_5678, 4);
    check("drop_no_pulse", 64'(p0_cnt - b0), 64'd0);
    check("drop_rdata", 64'(s9_rdata), 64'h12345678);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
